jogador_param: RTL

- Parametrised light-cycle player controller for the VGA trail game.
- Owns the player's position, heading, step timing, border and trail collision, trail writes into the shared framebuffer, and framebuffer clearing on restart.
- Talks to the framebuffer through explicit read and write request/acknowledge ports, so several instances can share one arbitrated RAM.
- Supplies a registered head-overlay bit to the pixel mixer.

---
 rtl/jogador_param.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/jogador_param.sv
// Light-cycle player controller for the VGA trail game.
// Owns position, heading, step timing, border/trail collision, trail writes
// and framebuffer clearing. Framebuffer access goes through request/acknowledge
// ports so several players can share one arbitrated RAM.
//
// Ports:
//   CLOCK_50, reset            clock and synchronous active-high reset
//   reiniciar                  restart: clear framebuffer, then READY
//   enable                     start request (READY only)
//   btn_ccw, btn_cw            active-low turn buttons
//   pixel_x, pixel_y           next pixel drawn by the VGA scan
//   fb_rd_*                    framebuffer read request/data
//   fb_wr_*                    framebuffer write request/accept
//   head_on                    registered head-overlay bit
//   pos_x, pos_y, dir          current cell and heading
//   ready, alive, crashed      status flags
module jogador_param #(
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned SCREEN_H   = 480,
  parameter int unsigned BORDER     = 16,
  parameter int unsigned CELL       = 8,
  parameter int unsigned START_X    = 216,
  parameter int unsigned START_Y    = 240,
  parameter int unsigned START_DIR  = 0,
  parameter int unsigned STEP_TICKS = 1000000,
  parameter logic [7:0]  TRAIL_CODE = 8'h01
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        reiniciar,
  input  logic        enable,
  input  logic        btn_ccw,
  input  logic        btn_cw,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  output logic        fb_rd_req,
  output logic [18:0] fb_rd_addr,
  input  logic        fb_rd_valid,
  input  logic [7:0]  fb_rd_data,
  output logic        fb_wr_en,
  output logic [18:0] fb_wr_addr,
  output logic [7:0]  fb_wr_data,
  input  logic        fb_wr_ready,
  output logic        head_on,
  output logic [9:0]  pos_x,
  output logic [9:0]  pos_y,
  output logic [1:0]  dir,
  output logic        ready,
  output logic        alive,
  output logic        crashed
);

  localparam int unsigned Total = SCREEN_W * SCREEN_H;
  localparam int unsigned CellW = (CELL > 1) ? $clog2(CELL) : 1;

  typedef enum logic [2:0] {StClear, StReady, StRun, StRead, StWrite, StDead} state_e;

  state_e           state_q, state_d;
  logic [18:0]      addr_q, addr_d;    // clear counter in CLEAR, trail address in WRITE
  logic [31:0]      step_q, step_d;
  logic [1:0]       pend_q, pend_d;    // pending turn as a heading delta; 0 = none
  logic [1:0]       dir_q, dir_d;
  logic [9:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [9:0]       fut_x_q, fut_x_d, fut_y_q, fut_y_d;
  logic [CellW-1:0] row_q, row_d, col_q, col_d;
  logic             cw_q, ccw_q, head_q;

  logic [1:0] new_dir;
  logic [9:0] nxt_x, nxt_y;
  logic       hit_border;
  logic       cw_fall, ccw_fall;

  assign cw_fall  = cw_q & ~btn_cw;
  assign ccw_fall = ccw_q & ~btn_ccw;

  // Next cell along the heading after the pending turn. Left/up test before
  // subtracting so the 10-bit coordinate never wraps.
  always_comb begin
    new_dir    = dir_q + pend_q;
    nxt_x      = pos_x_q;
    nxt_y      = pos_y_q;
    hit_border = 1'b0;
    case (new_dir)
      2'd0: begin
        hit_border = ({1'b0, pos_x_q} + 11'(CELL)) >= 11'(SCREEN_W - BORDER);
        nxt_x      = pos_x_q + 10'(CELL);
      end
      2'd1: begin
        hit_border = ({1'b0, pos_y_q} + 11'(CELL)) >= 11'(SCREEN_H - BORDER);
        nxt_y      = pos_y_q + 10'(CELL);
      end
      2'd2: begin
        hit_border = pos_x_q < 10'(BORDER + CELL);
        nxt_x      = pos_x_q - 10'(CELL);
      end
      default: begin
        hit_border = pos_y_q < 10'(BORDER + CELL);
        nxt_y      = pos_y_q - 10'(CELL);
      end
    endcase
  end

  assign fb_rd_addr = 19'(fut_y_q) * 19'(SCREEN_W) + 19'(fut_x_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    step_d     = step_q;
    pend_d     = pend_q;
    dir_d      = dir_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    fut_x_d    = fut_x_q;
    fut_y_d    = fut_y_q;
    row_d      = row_q;
    col_d      = col_q;
    fb_rd_req  = 1'b0;
    fb_wr_en   = 1'b0;
    fb_wr_addr = addr_q;
    fb_wr_data = 8'h00;

    case (state_q)
      StClear: begin
        fb_wr_en = 1'b1;
        if (fb_wr_ready) begin
          if (addr_q == 19'(Total - 1)) begin
            state_d = StReady;
            addr_d  = '0;
            pos_x_d = 10'(START_X);
            pos_y_d = 10'(START_Y);
            dir_d   = 2'(START_DIR);
          end else begin
            addr_d = addr_q + 19'd1;
          end
        end
      end
      StReady: begin
        if (enable) begin
          state_d = StRun;
          step_d  = '0;
        end
      end
      StRun: begin
        if (step_q == 32'(STEP_TICKS - 1)) begin
          step_d  = '0;
          dir_d   = new_dir;
          pend_d  = 2'd0;
          fut_x_d = nxt_x;
          fut_y_d = nxt_y;
          state_d = hit_border ? StDead : StRead;
        end else begin
          step_d = step_q + 32'd1;
        end
      end
      StRead: begin
        fb_rd_req = 1'b1;
        if (fb_rd_valid) begin
          if (fb_rd_data != 8'h00) begin
            state_d = StDead;
          end else begin
            state_d = StWrite;
            addr_d  = 19'(pos_y_q) * 19'(SCREEN_W) + 19'(pos_x_q);
            row_d   = '0;
            col_d   = '0;
          end
        end
      end
      StWrite: begin
        fb_wr_en   = 1'b1;
        fb_wr_data = TRAIL_CODE;
        if (fb_wr_ready) begin
          if (col_q == CellW'(CELL - 1)) begin
            col_d = '0;
            if (row_q == CellW'(CELL - 1)) begin
              pos_x_d = fut_x_q;
              pos_y_d = fut_y_q;
              state_d = StRun;
            end else begin
              row_d  = row_q + CellW'(1);
              addr_d = addr_q + 19'(SCREEN_W - CELL + 1);
            end
          end else begin
            col_d  = col_q + CellW'(1);
            addr_d = addr_q + 19'd1;
          end
        end
      end
      StDead: ;
      default: state_d = StClear;
    endcase

    // Turn edges only count while playing; a simultaneous pair cancels out.
    if ((state_q == StRun || state_q == StRead || state_q == StWrite) && (cw_fall ^ ccw_fall)) begin
      pend_d = cw_fall ? 2'd1 : 2'd3;
    end

    if (reiniciar) begin
      state_d = StClear;
      addr_d  = '0;
      step_d  = '0;
      pend_d  = 2'd0;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= StClear;
      addr_q  <= '0;
      step_q  <= '0;
      pend_q  <= 2'd0;
      dir_q   <= 2'(START_DIR);
      pos_x_q <= 10'(START_X);
      pos_y_q <= 10'(START_Y);
      fut_x_q <= '0;
      fut_y_q <= '0;
      row_q   <= '0;
      col_q   <= '0;
      cw_q    <= 1'b1;
      ccw_q   <= 1'b1;
      head_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      step_q  <= step_d;
      pend_q  <= pend_d;
      dir_q   <= dir_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      fut_x_q <= fut_x_d;
      fut_y_q <= fut_y_d;
      row_q   <= row_d;
      col_q   <= col_d;
      cw_q    <= btn_cw;
      ccw_q   <= btn_ccw;
      head_q  <= (state_q != StClear) &&
                 ({1'b0, pixel_x} >= {1'b0, pos_x_q}) &&
                 ({1'b0, pixel_x} < ({1'b0, pos_x_q} + 11'(CELL))) &&
                 ({1'b0, pixel_y} >= {1'b0, pos_y_q}) &&
                 ({1'b0, pixel_y} < ({1'b0, pos_y_q} + 11'(CELL)));
    end
  end

  assign head_on = head_q;
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign dir     = dir_q;
  assign ready   = (state_q == StReady);
  assign alive   = (state_q == StRun) || (state_q == StRead) || (state_q == StWrite);
  assign crashed = (state_q == StDead);

endmodule
